// File: rtl/adc_seq_pkg.sv
// Shared constants for the ADC sequencer: register map, bit positions, FSM states, timeout.
package adc_seq_pkg;

  localparam logic [3:0] OFS_CTRL   = 4'h0;
  localparam logic [3:0] OFS_PERIOD = 4'h4;
  localparam logic [3:0] OFS_STATUS = 4'h8;
  localparam logic [3:0] OFS_DATA   = 4'hC;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_ONESHOT = 1;
  localparam int unsigned CTRL_IRQ_EN  = 2;

  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_EMPTY     = 1;
  localparam int unsigned STAT_FULL      = 2;
  localparam int unsigned STAT_OVF       = 3;
  localparam int unsigned STAT_TMO       = 4;
  localparam int unsigned STAT_COUNT_LSB = 8;

  localparam int unsigned TIMEOUT_CYC = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_READ,
    ST_STORE
  } seq_state_e;

endpackage

// File: rtl/adc_seq_fifo.sv
// Synchronous result FIFO; a push into a full FIFO succeeds only when a pop frees a slot.
module adc_seq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   RSTn,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/adc_seq_ctrl.sv
// APB-programmed ADC conversion sequencer with result FIFO and level interrupt.
// Define ADC_SEQ_TIMEOUT_EN to abandon a conversion whose EOC never arrives.
module adc_seq_ctrl
  import adc_seq_pkg::*;
#(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned START_W    = 2
) (
  input  logic              clk,
  input  logic              RSTn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [3:0]        PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              adc_start,
  output logic              adc_oe,
  input  logic              adc_eoc,
  input  logic [DATA_W-1:0] adc_data,
  output logic              irq
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  seq_state_e        state_q, state_d;
  logic              en_q, en_d, oneshot_q, oneshot_d, irq_en_q, irq_en_d;
  logic [15:0]       period_q, period_d, per_cnt_q, per_cnt_d;
  logic [8:0]        tmr_q, tmr_d;
  logic              ovf_q, ovf_d, tmo_q, tmo_d, tmo_set;
  logic              acc, addr_ok, wr, rd, push, pop;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic [CNT_W-1:0]  fifo_count;
  logic [31:0]       rdata;
  logic [15:0]       unused_pwdata;

  assign unused_pwdata = PWDATA[31:16];

  assign acc     = PSEL & PENABLE;
  assign addr_ok = (PADDR[1:0] == 2'b00);
  assign wr      = acc & PWRITE & addr_ok;
  assign rd      = acc & ~PWRITE & addr_ok;
  assign pop     = rd & (PADDR == OFS_DATA) & ~fifo_empty;
  assign push    = (state_q == ST_STORE);

  assign PREADY    = 1'b1;
  assign PSLVERR   = RSTn & acc & ~addr_ok;
  assign adc_start = (state_q == ST_START);
  assign adc_oe    = (state_q == ST_READ);
  assign irq       = irq_en_q & (~fifo_empty | ovf_q | tmo_q);

  adc_seq_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(DATA_W)
  ) u_fifo (
    .clk  (clk),
    .RSTn (RSTn),
    .push (push),
    .pop  (pop),
    .din  (adc_data),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    tmo_set   = 1'b0;
    per_cnt_d = (per_cnt_q != '0) ? per_cnt_q - 16'd1 : '0;
    case (state_q)
      ST_IDLE: begin
        if (oneshot_q || (en_q && per_cnt_q == '0)) begin
          state_d = ST_START;
          tmr_d   = '0;
          // Loaded one short because the start cycle itself is the first of the PERIOD cycles.
          per_cnt_d = (period_q == '0) ? '0 : period_q - 16'd1;
        end
      end
      ST_START: begin
        if (tmr_q == 9'(START_W - 1)) begin
          state_d = ST_WAIT;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 9'd1;
        end
      end
      ST_WAIT: begin
        if (adc_eoc) begin
          state_d = ST_READ;
        end
`ifdef ADC_SEQ_TIMEOUT_EN
        else if (tmr_q == 9'(TIMEOUT_CYC - 1)) begin
          state_d = ST_IDLE;
          tmo_set = 1'b1;
        end else begin
          tmr_d = tmr_q + 9'd1;
        end
`endif
      end
      ST_READ:  state_d = ST_STORE;
      ST_STORE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    en_d      = en_q;
    irq_en_d  = irq_en_q;
    oneshot_d = 1'b0;
    period_d  = period_q;
    ovf_d     = ovf_q;
    tmo_d     = tmo_q;
    if (wr && PADDR == OFS_CTRL) begin
      en_d      = PWDATA[CTRL_EN];
      oneshot_d = PWDATA[CTRL_ONESHOT];
      irq_en_d  = PWDATA[CTRL_IRQ_EN];
    end
    if (wr && PADDR == OFS_PERIOD) period_d = PWDATA[15:0];
    if (wr && PADDR == OFS_STATUS) begin
      if (PWDATA[STAT_OVF]) ovf_d = 1'b0;
      if (PWDATA[STAT_TMO]) tmo_d = 1'b0;
    end
    if (push && fifo_full && !pop) ovf_d = 1'b1;
    if (tmo_set) tmo_d = 1'b1;
  end

  always_comb begin
    rdata = '0;
    case (PADDR)
      OFS_CTRL: begin
        rdata[CTRL_EN]     = en_q;
        rdata[CTRL_IRQ_EN] = irq_en_q;
      end
      OFS_PERIOD: rdata[15:0] = period_q;
      OFS_STATUS: begin
        rdata[STAT_BUSY]                  = (state_q != ST_IDLE);
        rdata[STAT_EMPTY]                 = fifo_empty;
        rdata[STAT_FULL]                  = fifo_full;
        rdata[STAT_OVF]                   = ovf_q;
        rdata[STAT_TMO]                   = tmo_q;
        rdata[STAT_COUNT_LSB +: CNT_W]    = fifo_count;
      end
      OFS_DATA: if (!fifo_empty) rdata[DATA_W-1:0] = fifo_dout;
      default: rdata = '0;
    endcase
    PRDATA = (RSTn && acc && !PWRITE) ? rdata : '0;
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= ST_IDLE;
      en_q      <= 1'b0;
      oneshot_q <= 1'b0;
      irq_en_q  <= 1'b0;
      period_q  <= '0;
      per_cnt_q <= '0;
      tmr_q     <= '0;
      ovf_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      oneshot_q <= oneshot_d;
      irq_en_q  <= irq_en_d;
      period_q  <= period_d;
      per_cnt_q <= per_cnt_d;
      tmr_q     <= tmr_d;
      ovf_q     <= ovf_d;
      tmo_q     <= tmo_d;
    end
  end

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Directed self-checking bench for adc_seq_ctrl; build with ADC_SEQ_TIMEOUT_EN to cover the timeout.
module tb_adc_seq_ctrl;

  logic        clk = 1'b0;
  logic        RSTn;
  logic        PSEL, PENABLE, PWRITE;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        adc_start, adc_oe, adc_eoc;
  logic [11:0] adc_data;
  logic        irq;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned n_start_hi = 0;
  int unsigned n_oe     = 0;
  int unsigned n_eoc    = 0;
  int unsigned start_cyc[$];
  int unsigned eoc_timer = 0;
  logic        start_prev = 1'b0;
  logic        model_en;
  logic [31:0] data_base;

  adc_seq_ctrl #(.DATA_W(12), .FIFO_DEPTH(4), .START_W(2)) dut (
    .clk(clk), .RSTn(RSTn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .adc_start(adc_start), .adc_oe(adc_oe), .adc_eoc(adc_eoc), .adc_data(adc_data), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor plus ADC model: EOC rises 10 cycles after a start and holds until OE.
  initial begin
    adc_eoc  = 1'b0;
    adc_data = '0;
    forever begin
      @(negedge clk);
      if (adc_start) n_start_hi++;
      if (adc_oe) begin
        n_oe++;
        adc_eoc = 1'b0;
      end
      if (eoc_timer != 0) begin
        eoc_timer--;
        if (eoc_timer == 0) begin
          adc_eoc  = 1'b1;
          adc_data = 12'(data_base + n_eoc);
          n_eoc++;
        end
      end
      if (adc_start && !start_prev) begin
        start_cyc.push_back(cyc);
        if (model_en) eoc_timer = 10;
      end
      start_prev = adc_start;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(negedge clk);
    PENABLE = 1'b1;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d, output logic e);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(negedge clk);
    PENABLE = 1'b1;
    #1;
    d = PRDATA;
    e = PSLVERR;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    apb_read(a, d, e);
    check_eq(tag, d, exp);
  endtask

  task automatic wait_oe(input int unsigned target, input int unsigned budget);
    int unsigned g = 0;
    while (n_oe < target && g < budget) begin
      @(negedge clk);
      g++;
    end
    check_eq("wait_oe", 32'(n_oe >= target), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    int unsigned b_oe, b_hi, b_st, g;

    RSTn = 1'b0; PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 4'h6; PWDATA = '0;
    model_en = 1'b1; data_base = '0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_prdata", PRDATA, 32'h0);
    check_eq("rst_pslverr", 32'(PSLVERR), 32'h0);
    check_eq("rst_pready", 32'(PREADY), 32'h1);
    check_eq("rst_irq", 32'(irq), 32'h0);
    check_eq("rst_start_oe", 32'({adc_start, adc_oe}), 32'h0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge clk);
    RSTn = 1'b1;
    @(negedge clk);
    read_chk("rst_status", 4'h8, 32'h2);
    read_chk("rst_ctrl", 4'h0, 32'h0);
    read_chk("rst_period", 4'h4, 32'h0);

    // Single oneshot conversion
    b_oe = n_oe; b_hi = n_start_hi;
    data_base = 32'hABC - n_eoc;
    apb_write(4'h0, 32'h2);
    wait_oe(b_oe + 1, 100);
    repeat (20) @(negedge clk);
    check_eq("os_start_width", n_start_hi - b_hi, 2);
    check_eq("os_oe_pulses", n_oe - b_oe, 1);
    read_chk("os_ctrl_clear", 4'h0, 32'h0);
    read_chk("os_status1", 4'h8, 32'h100);
    read_chk("os_data", 4'hC, 32'h0000_0ABC);
    read_chk("os_status2", 4'h8, 32'h2);
    read_chk("empty_data", 4'hC, 32'h0);

    // Bad offsets and interrupt
    apb_read(4'h6, d, e);
    check_eq("bad_prdata", d, 32'h0);
    check_eq("bad_pslverr", 32'(e), 32'h1);
    apb_read(4'h4, d, e);
    check_eq("good_pslverr", 32'(e), 32'h0);
    apb_write(4'h0, 32'h4);
    check_eq("irq_empty", 32'(irq), 32'h0);
    b_oe = n_oe;
    data_base = 32'h5A5 - n_eoc;
    apb_write(4'h0, 32'h6);
    wait_oe(b_oe + 1, 100);
    repeat (3) @(negedge clk);
    check_eq("irq_set", 32'(irq), 32'h1);
    read_chk("irq_data", 4'hC, 32'h5A5);
    check_eq("irq_clear", 32'(irq), 32'h0);

    // Continuous mode, PERIOD=100, overflow on 5th sample
    b_oe = n_oe; b_st = start_cyc.size();
    data_base = 32'h100 - n_eoc;
    apb_write(4'h4, 32'd100);
    apb_write(4'h0, 32'h1);
    wait_oe(b_oe + 5, 1000);
    apb_write(4'h0, 32'h0);
    repeat (200) @(negedge clk);
    check_eq("cont_starts", start_cyc.size() - b_st, 5);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("cont_gap%0d", i),
               start_cyc[b_st + i + 1] - start_cyc[b_st + i], 32'd100);
    read_chk("cont_status_ovf", 4'h8, 32'h40C);
    apb_write(4'h8, 32'h8);
    read_chk("ovf_w1c", 4'h8, 32'h404);

    // Pop in the same cycle as STORE on a full FIFO
    data_base = 32'h200 - n_eoc;
    apb_write(4'h0, 32'h2);
    g = 0;
    while (!adc_oe && g < 100) begin
      @(negedge clk);
      g++;
    end
    check_eq("sim_oe_seen", 32'(adc_oe), 32'h1);
    read_chk("sim_pop0", 4'hC, 32'h100);
    read_chk("sim_status", 4'h8, 32'h404);
    read_chk("sim_pop1", 4'hC, 32'h101);
    read_chk("sim_pop2", 4'hC, 32'h102);
    read_chk("sim_pop3", 4'hC, 32'h103);
    read_chk("sim_pop4", 4'hC, 32'h200);
    read_chk("sim_drained", 4'h8, 32'h2);

    // Reset while adc_start is high
    model_en = 1'b0;
    apb_write(4'h0, 32'h2);
    g = 0;
    while (!adc_start && g < 20) begin
      @(negedge clk);
      g++;
    end
    check_eq("rs_start_seen", 32'(adc_start), 32'h1);
    RSTn = 1'b0;
    #1;
    check_eq("rs_start_low", 32'(adc_start), 32'h0);
    @(negedge clk);
    RSTn = 1'b1;
    @(negedge clk);
    read_chk("rs_status", 4'h8, 32'h2);

    // Reset while waiting for EOC
    apb_write(4'h0, 32'h2);
    repeat (20) @(negedge clk);
    read_chk("rw_busy", 4'h8, 32'h3);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 4'h8;
    RSTn = 1'b0;
    #1;
    check_eq("rw_start_oe", 32'({adc_start, adc_oe}), 32'h0);
    check_eq("rw_prdata", PRDATA, 32'h0);
    check_eq("rw_pready", 32'(PREADY), 32'h1);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge clk);
    RSTn = 1'b1;
    @(negedge clk);
    read_chk("rw_status", 4'h8, 32'h2);

    b_oe = n_oe;
    apb_write(4'h0, 32'h2);
`ifdef ADC_SEQ_TIMEOUT_EN
    repeat (250) @(negedge clk);
    read_chk("tmo_before", 4'h8, 32'h3);
    repeat (20) @(negedge clk);
    read_chk("tmo_set", 4'h8, 32'h12);
    check_eq("tmo_no_oe", n_oe - b_oe, 0);
    apb_write(4'h8, 32'h10);
    read_chk("tmo_w1c", 4'h8, 32'h2);
`else
    repeat (300) @(negedge clk);
    read_chk("no_tmo_wait", 4'h8, 32'h3);
    check_eq("no_tmo_oe", n_oe - b_oe, 0);
    RSTn = 1'b0;
    @(negedge clk);
    RSTn = 1'b1;
    @(negedge clk);
    read_chk("no_tmo_reset", 4'h8, 32'h2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
